pixel_state_ctrl: RTL and testbench

PIXEL_STATE_CTRL -- requirements
Module: pixel_state_ctrl

---
 rtl/pixel_state_ctrl.sv | 159 +++++++++++++++
 tb/tb_pixel_state_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_state_ctrl.sv
// Pixel sequencing controller: erase -> expose -> convert -> row readout.
// Optional frame counter output is enabled by defining PIXEL_CTRL_FRAME_CNT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; frame_done pulses here right after S_READ
// S_ERASE   | erase strobe high for ERASE_CYCLES cycles
// S_EXPOSE  | expose high for EXPOSE_CYCLES cycles
// S_CONVERT | convert high for CONVERT_CYCLES cycles (one ramp)
// S_READ    | read high for NUM_ROWS cycles, read_row counts 0..NUM_ROWS-1
module pixel_state_ctrl #(
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255,
  parameter int NUM_ROWS       = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic        read,
  output logic [7:0]  read_row,
  output logic        busy,
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_done
);

  if (ERASE_CYCLES < 1 || ERASE_CYCLES > 65535) begin : g_bad_erase
    $error("pixel_state_ctrl: ERASE_CYCLES must be within 1..65535");
  end
  if (EXPOSE_CYCLES < 1 || EXPOSE_CYCLES > 65535) begin : g_bad_expose
    $error("pixel_state_ctrl: EXPOSE_CYCLES must be within 1..65535");
  end
  if (CONVERT_CYCLES < 1 || CONVERT_CYCLES > 65535) begin : g_bad_convert
    $error("pixel_state_ctrl: CONVERT_CYCLES must be within 1..65535");
  end
  if (NUM_ROWS < 1 || NUM_ROWS > 65535) begin : g_bad_rows
    $error("pixel_state_ctrl: NUM_ROWS must be within 1..65535");
  end

  // Last phase-counter value of each timed state.
  localparam logic [15:0] ERASE_LAST   = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] EXPOSE_LAST  = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0] CONVERT_LAST = 16'(CONVERT_CYCLES - 1);
  localparam logic [15:0] READ_LAST    = 16'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;

  logic        r_erase, r_expose, r_convert, r_read, r_busy, r_frame_done;
  logic [7:0]  r_read_row;
  logic        w_erase_nxt, w_expose_nxt, w_convert_nxt, w_read_nxt, w_busy_nxt;
  logic        w_frame_done_nxt;
  logic [7:0]  w_read_row_nxt;

  // State and phase counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decode; abort overrides everything outside IDLE and also blocks start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start && !abort)           w_state_nxt = S_ERASE;
      S_ERASE:   if (abort)                     w_state_nxt = S_IDLE;
                 else if (r_cnt == ERASE_LAST)   w_state_nxt = S_EXPOSE;
      S_EXPOSE:  if (abort)                     w_state_nxt = S_IDLE;
                 else if (r_cnt == EXPOSE_LAST)  w_state_nxt = S_CONVERT;
      S_CONVERT: if (abort)                     w_state_nxt = S_IDLE;
                 else if (r_cnt == CONVERT_LAST) w_state_nxt = S_READ;
      S_READ:    if (abort || r_cnt == READ_LAST) w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
    // Counter restarts at 0 on every state change and is parked at 0 in IDLE.
    if (w_state_nxt != r_state || w_state_nxt == S_IDLE) begin
      w_cnt_nxt = 16'd0;
    end else begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // Output decode from the upcoming state so the registered strobes align with the state.
  always_comb begin
    w_erase_nxt      = (w_state_nxt == S_ERASE);
    w_expose_nxt     = (w_state_nxt == S_EXPOSE);
    w_convert_nxt    = (w_state_nxt == S_CONVERT);
    w_read_nxt       = (w_state_nxt == S_READ);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_read_row_nxt   = (w_state_nxt == S_READ) ? w_cnt_nxt[7:0] : 8'd0;
    w_frame_done_nxt = (r_state == S_READ) && (w_state_nxt == S_IDLE) && !abort;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_convert    <= 1'b0;
      r_read       <= 1'b0;
      r_busy       <= 1'b0;
      r_read_row   <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_erase      <= w_erase_nxt;
      r_expose     <= w_expose_nxt;
      r_convert    <= w_convert_nxt;
      r_read       <= w_read_nxt;
      r_busy       <= w_busy_nxt;
      r_read_row   <= w_read_row_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign erase      = r_erase;
  assign expose     = r_expose;
  assign convert    = r_convert;
  assign read       = r_read;
  assign busy       = r_busy;
  assign read_row   = r_read_row;
  assign frame_done = r_frame_done;

`ifdef PIXEL_CTRL_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter; updates together with frame_done and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= 16'd0;
    end else if (w_frame_done_nxt) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_pixel_state_ctrl.sv
// Directed bench for pixel_state_ctrl with a frame_done timing scoreboard.
// Frame counter checks are compiled in when PIXEL_CTRL_FRAME_CNT_EN is defined.
module tb_pixel_state_ctrl;

  localparam int LE    = 5;
  localparam int LX    = 255;
  localparam int LC    = 255;
  localparam int LR    = 2;
  localparam int FRAME = LE + LX + LC + LR + 1;  // start-sample negedge to frame_done negedge

  logic       clk = 1'b0;
  logic       reset_n, start, abort;
  logic       erase, expose, convert, read, busy, frame_done;
  logic [7:0] read_row;
`ifdef PIXEL_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int exp_q[$];
  int exp_fcnt = 0;

  pixel_state_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read       (read),
    .read_row   (read_row),
    .busy       (busy),
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fcnt(input string tag);
`ifdef PIXEL_CTRL_FRAME_CNT_EN
    chk(tag, {16'd0, frame_cnt}, 32'(exp_fcnt));
`endif
  endtask

  // Always-on checks: strobe exclusivity, frames only start from idle, frame_done scoreboard.
  logic p_erase = 1'b0, p_busy = 1'b0;
  always @(negedge clk) begin
    chk("onehot_strobes", {31'd0, $countones({erase, expose, convert, read}) <= 1}, 32'd1);
    if (erase && !p_erase) chk("erase_only_from_idle", {31'd0, p_busy}, 32'd0);
    if (frame_done) begin
      if (exp_q.size() == 0) chk("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
      else                   chk("frame_done_cycle", 32'(cyc), 32'(exp_q.pop_front()));
    end
    p_erase = erase;
    p_busy  = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int first[4], last[4], cnt[4];
  int row_bad, done_at, idle_cnt, done_cnt, e_cnt;
  logic busy_at_done;
  logic w[4];

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_strobes", {26'd0, erase, expose, convert, read, busy, frame_done}, 32'd0);
    chk("reset_read_row", {24'd0, read_row}, 32'd0);
    chk_fcnt("reset_frame_cnt");

    // Full default frame, start accepted on the first edge after release; start pulsed mid-frame.
    reset_n = 1'b1; start = 1'b1;
    exp_q.push_back(cyc + FRAME);
    exp_fcnt++;
    for (int s = 0; s < 4; s++) begin first[s] = 0; last[s] = 0; cnt[s] = 0; end
    row_bad = 0; done_at = 0; busy_at_done = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      w = '{erase, expose, convert, read};
      for (int s = 0; s < 4; s++) begin
        if (w[s]) begin
          if (cnt[s] == 0) first[s] = k;
          last[s] = k;
          cnt[s]++;
        end
      end
      if (read) begin
        if (read_row != 8'(k - (LE + LX + LC + 1))) row_bad++;
      end else if (read_row != 8'd0) row_bad++;
      if (frame_done) begin done_at = k; busy_at_done = busy; end
      start = (k == 50);
    end
    chk("erase_first",   32'(first[0]), 32'd1);
    chk("erase_len",     32'(cnt[0]),   32'(LE));
    chk("expose_first",  32'(first[1]), 32'(LE + 1));
    chk("expose_last",   32'(last[1]),  32'(LE + LX));
    chk("expose_len",    32'(cnt[1]),   32'(LX));
    chk("convert_first", 32'(first[2]), 32'(LE + LX + 1));
    chk("convert_len",   32'(cnt[2]),   32'(LC));
    chk("read_first",    32'(first[3]), 32'(LE + LX + LC + 1));
    chk("read_len",      32'(cnt[3]),   32'(LR));
    chk("read_row_seq",  32'(row_bad),  32'd0);
    chk("frame_done_at", 32'(done_at),  32'(FRAME));
    chk("busy_at_done",  {31'd0, busy_at_done}, 32'd0);
    @(negedge clk);
    chk("idle_after_frame", {30'd0, busy, frame_done}, 32'd0);
    chk_fcnt("frame_cnt_after_first");

    // Abort on the 100th expose cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LE + 99) @(negedge clk);
    chk("expose_100th", {31'd0, expose}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_strobes", {27'd0, erase, expose, convert, read, busy}, 32'd0);
    repeat (FRAME + 80) @(negedge clk);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);
    chk_fcnt("frame_cnt_after_abort");

    // start and abort together in idle.
    start = 1'b1; abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("start_abort_busy",  {31'd0, busy},  32'd0);
      chk("start_abort_erase", {31'd0, erase}, 32'd0);
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-convert, then a full frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    chk("convert_before_reset", {31'd0, convert}, 32'd1);
    #2 reset_n = 1'b0;
    exp_fcnt = 0;
    #1;
    chk("async_reset_outputs", {18'd0, erase, expose, convert, read, busy, frame_done, read_row}, 32'd0);
    chk_fcnt("async_reset_frame_cnt");
    @(negedge clk);
    reset_n = 1'b1; start = 1'b1;
    exp_q.push_back(cyc + FRAME);
    exp_fcnt++;
    @(negedge clk);
    start = 1'b0;
    chk("erase_after_reset", {30'd0, erase, busy}, 32'd3);
    repeat (FRAME + 2) @(negedge clk);
    chk("queue_after_reset_frame", 32'(exp_q.size()), 32'd0);
    chk_fcnt("frame_cnt_after_reset_frame");

    // Three back-to-back frames with start held high.
    start = 1'b1;
    for (int f = 1; f <= 3; f++) exp_q.push_back(cyc + f * FRAME);
    exp_fcnt += 3;
    idle_cnt = 0; done_cnt = 0; e_cnt = 0;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (frame_done) done_cnt++;
      if (erase) e_cnt++;
      if (k == FRAME + 1) chk("b2b_restart", {31'd0, erase}, 32'd1);
      if (k == 3 * FRAME) start = 1'b0;
    end
    chk("b2b_idle_cycles", 32'(idle_cnt), 32'd3);
    chk("b2b_frame_done",  32'(done_cnt), 32'd3);
    chk("b2b_erase_total", 32'(e_cnt),    32'(3 * LE));
    repeat (3) @(negedge clk);
    chk("b2b_no_fourth", {31'd0, busy}, 32'd0);
    chk("queue_empty",   32'(exp_q.size()), 32'd0);
    chk_fcnt("frame_cnt_after_b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
